// File: rtl/load_store_unit_if.sv
// Bundle of the request/response handshake and the data-memory bus seen by
// the load/store unit. The slave side is the LSU; the master side is the
// datapath plus memory that surrounds it.
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] rdata;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wr;
    logic [63:0] mem_rdata;

    modport slave (
        input  req, we, funct3, addr, wdata, mem_rdata,
        output busy, done, err, rdata, mem_addr, mem_wdata, mem_wr
    );

    modport master (
        output req, we, funct3, addr, wdata, mem_rdata,
        input  busy, done, err, rdata, mem_addr, mem_wdata, mem_wr
    );
endinterface

// File: rtl/load_store_unit.sv
// RV64I load/store unit: turns byte/half/word/double accesses into
// doubleword-aligned memory cycles. Partial stores read the line, merge the
// new lanes and write it back; loads extract and extend the addressed lanes.
module load_store_unit #(
    parameter int READ_LAT = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    load_store_unit_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, RD, MRG, WR, DONE} state_t;

    localparam logic [2:0] LAST_RD = 3'(READ_LAT - 1);

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [2:0]  off_q;
    logic [63:0] wdata_q;
    logic        err_q;
    logic [2:0]  cnt_q;
    logic [63:0] line_q;
    logic [63:0] rdata_q;
    logic [63:0] mem_addr_q;
    logic [63:0] mem_wdata_q;

    logic        illegal;
    logic        misaligned;
    logic        bad;
    logic        is_sd;

    // Replace the addressed byte lanes of a line with the low bytes of data.
    function automatic logic [63:0] merge_line(input logic [63:0] line,
                                               input logic [63:0] data,
                                               input logic [1:0]  size,
                                               input logic [2:0]  off);
        logic [7:0]  lanes;
        logic [63:0] shifted;
        logic [63:0] merged;
        case (size)
            2'd0:    lanes = 8'h01;
            2'd1:    lanes = 8'h03;
            2'd2:    lanes = 8'h0F;
            default: lanes = 8'hFF;
        endcase
        lanes   = lanes << off;
        shifted = data << {off, 3'b000};
        merged  = line;
        for (int k = 0; k < 8; k++) begin
            if (lanes[k]) merged[8*k +: 8] = shifted[8*k +: 8];
        end
        return merged;
    endfunction

    // Pull the addressed lanes down to bit 0 and sign- or zero-extend them.
    function automatic logic [63:0] extend_load(input logic [63:0] line,
                                                input logic [2:0]  f3,
                                                input logic [2:0]  off);
        logic [63:0] sh;
        sh = line >> {off, 3'b000};
        case (f3)
            3'b000:  return {{56{sh[7]}},  sh[7:0]};
            3'b001:  return {{48{sh[15]}}, sh[15:0]};
            3'b010:  return {{32{sh[31]}}, sh[31:0]};
            3'b100:  return {56'd0, sh[7:0]};
            3'b101:  return {48'd0, sh[15:0]};
            3'b110:  return {32'd0, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    assign illegal    = bus.we ? bus.funct3[2] : (bus.funct3 == 3'b111);
    assign misaligned = ((bus.funct3[1:0] == 2'd1) && bus.addr[0])            ||
                        ((bus.funct3[1:0] == 2'd2) && (bus.addr[1:0] != 2'd0)) ||
                        ((bus.funct3[1:0] == 2'd3) && (bus.addr[2:0] != 3'd0));
    assign bad        = illegal | misaligned;
    assign is_sd      = bus.we && (bus.funct3 == 3'b011);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a full doubleword store skips the read and merge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (bad)        state_d = DONE;
                    else if (is_sd) state_d = WR;
                    else            state_d = RD;
                end
            end
            RD:      if (cnt_q == LAST_RD) state_d = we_q ? MRG : DONE;
            MRG:     state_d = WR;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, read-count, line capture, load result and merge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 3'd0;
            wdata_q     <= 64'd0;
            err_q       <= 1'b0;
            cnt_q       <= 3'd0;
            line_q      <= 64'd0;
            rdata_q     <= 64'd0;
            mem_addr_q  <= 64'd0;
            mem_wdata_q <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        f3_q    <= bus.funct3;
                        off_q   <= bus.addr[2:0];
                        wdata_q <= bus.wdata;
                        err_q   <= bad;
                        cnt_q   <= 3'd0;
                        if (!bad) begin
                            mem_addr_q <= {bus.addr[63:3], 3'b000};
                            if (is_sd) mem_wdata_q <= bus.wdata;
                        end
                    end
                end
                RD: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == LAST_RD) begin
                        line_q <= bus.mem_rdata;
                        if (!we_q) rdata_q <= extend_load(bus.mem_rdata, f3_q, off_q);
                    end
                end
                MRG:     mem_wdata_q <= merge_line(line_q, wdata_q, f3_q[1:0], off_q);
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = (state_q == DONE) && err_q;
    assign bus.mem_wr    = (state_q == WR);
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance with READ_LAT=1 for the
// main scenarios and one with READ_LAT=3 for the longer read latency.
module tb_load_store_unit;

    logic Clk = 1'b0;
    logic Reset;
    logic preload;
    int   checks = 0;
    int   errors = 0;

    load_store_unit_if b1();
    load_store_unit_if b2();

    load_store_unit #(.READ_LAT(1)) dut1 (.Clk(Clk), .Reset(Reset), .bus(b1.slave));
    load_store_unit #(.READ_LAT(3)) dut2 (.Clk(Clk), .Reset(Reset), .bus(b2.slave));

    always #5 Clk = ~Clk;

    // Memory models: mem1 answers in the same cycle as mem_addr (latency 1),
    // mem2 goes through two extra register stages (latency 3).
    logic [63:0] mem1 [0:15];
    logic [63:0] mem2 [0:15];
    logic [63:0] rd2_p1, rd2_p2;

    assign b1.mem_rdata = mem1[b1.mem_addr[6:3]];
    assign b2.mem_rdata = rd2_p2;

    always @(posedge Clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                mem1[i] <= {8{8'(i)}};
                mem2[i] <= {8{8'(i + 16)}};
            end
            mem1[2] <= 64'h8877665544332211;
            mem2[2] <= 64'h8877665544332211;
        end else begin
            if (b1.mem_wr) mem1[b1.mem_addr[6:3]] <= b1.mem_wdata;
            if (b2.mem_wr) mem2[b2.mem_addr[6:3]] <= b2.mem_wdata;
        end
        rd2_p1 <= mem2[b2.mem_addr[6:3]];
        rd2_p2 <= rd2_p1;
    end

    // Drive one access on instance 1 and report what happened, cycle numbers
    // counted from the acceptance edge (cycle 1 is the one right after it).
    task automatic run_access(input logic w, input logic [2:0] f, input logic [63:0] a,
                              input logic [63:0] d, output int done_cyc, output int wr_cnt,
                              output int wr_cyc, output logic [63:0] wr_addr,
                              output logic [63:0] wr_data, output logic err_o,
                              output logic [63:0] rd, output logic busy1);
        @(negedge Clk);
        b1.req = 1'b1; b1.we = w; b1.funct3 = f; b1.addr = a; b1.wdata = d;
        done_cyc = -1; wr_cnt = 0; wr_cyc = -1; wr_addr = 'x; wr_data = 'x;
        err_o = 1'bx; busy1 = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (k == 1) begin b1.req = 1'b0; busy1 = b1.busy; end
            if (b1.mem_wr) begin wr_cnt++; wr_cyc = k; wr_addr = b1.mem_addr; wr_data = b1.mem_wdata; end
            if (b1.done) begin done_cyc = k; err_o = b1.err; break; end
        end
        rd = b1.rdata;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", b1.busy); end
        checks++; if (b1.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", b1.done); end
        checks++; if (b1.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", b1.err); end
        checks++; if (b1.mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b expected 0", b1.mem_wr); end
        checks++; if (b1.rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", b1.rdata); end
        checks++; if (b1.mem_addr !== 64'd0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", b1.mem_addr); end
        checks++; if (b1.mem_wdata !== 64'd0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", b1.mem_wdata); end
        checks++; if (b2.busy !== 1'b0) begin errors++; $display("FAIL reset_busy2: got %b expected 0", b2.busy); end
        Reset = 1'b0;
    endtask

    task automatic test_loads();
        int dc, wc, wy; logic [63:0] wa, wd, rd; logic e, b;
        run_access(1'b0, 3'b000, 64'h17, 64'd0, dc, wc, wy, wa, wd, e, rd, b);
        checks++; if (dc !== 2) begin errors++; $display("FAIL lb_done_cycle: got %0d expected 2", dc); end
        checks++; if (rd !== 64'hFFFFFFFFFFFFFF88) begin errors++; $display("FAIL lb_rdata: got %h expected ffffffffffffff88", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL lb_err: got %b expected 0", e); end
        checks++; if (wc !== 0) begin errors++; $display("FAIL lb_mem_wr: got %0d pulses expected 0", wc); end
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL lb_busy: got %b expected 1", b); end
        run_access(1'b0, 3'b100, 64'h17, 64'd0, dc, wc, wy, wa, wd, e, rd, b);
        checks++; if (rd !== 64'h0000000000000088) begin errors++; $display("FAIL lbu_rdata: got %h expected 88", rd); end
        checks++; if (dc !== 2) begin errors++; $display("FAIL lbu_done_cycle: got %0d expected 2", dc); end
        run_access(1'b0, 3'b001, 64'h16, 64'd0, dc, wc, wy, wa, wd, e, rd, b);
        checks++; if (rd !== 64'hFFFFFFFFFFFF8877) begin errors++; $display("FAIL lh_rdata: got %h expected ffffffffffff8877", rd); end
        run_access(1'b0, 3'b010, 64'h14, 64'd0, dc, wc, wy, wa, wd, e, rd, b);
        checks++; if (rd !== 64'hFFFFFFFF88776655) begin errors++; $display("FAIL lw_rdata: got %h expected ffffffff88776655", rd); end
        run_access(1'b0, 3'b110, 64'h14, 64'd0, dc, wc, wy, wa, wd, e, rd, b);
        checks++; if (rd !== 64'h0000000088776655) begin errors++; $display("FAIL lwu_rdata: got %h expected 88776655", rd); end
        run_access(1'b0, 3'b011, 64'h10, 64'd0, dc, wc, wy, wa, wd, e, rd, b);
        checks++; if (rd !== 64'h8877665544332211) begin errors++; $display("FAIL ld_rdata: got %h expected 8877665544332211", rd); end
    endtask

    task automatic test_partial_store();
        int dc, wc, wy; logic [63:0] wa, wd, rd; logic e, b;
        run_access(1'b1, 3'b000, 64'h12, 64'h00000000000000AB, dc, wc, wy, wa, wd, e, rd, b);
        checks++; if (wc !== 1) begin errors++; $display("FAIL sb_wr_pulses: got %0d expected 1", wc); end
        checks++; if (wy !== 3) begin errors++; $display("FAIL sb_wr_cycle: got %0d expected 3", wy); end
        checks++; if (wa !== 64'h10) begin errors++; $display("FAIL sb_mem_addr: got %h expected 10", wa); end
        checks++; if (wd !== 64'h8877665544AB2211) begin errors++; $display("FAIL sb_mem_wdata: got %h expected 8877665544ab2211", wd); end
        checks++; if (dc !== 4) begin errors++; $display("FAIL sb_done_cycle: got %0d expected 4", dc); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL sb_err: got %b expected 0", e); end
        run_access(1'b0, 3'b011, 64'h10, 64'd0, dc, wc, wy, wa, wd, e, rd, b);
        checks++; if (rd !== 64'h8877665544AB2211) begin errors++; $display("FAIL sb_readback: got %h expected 8877665544ab2211", rd); end
    endtask

    task automatic test_sd();
        int dc, wc, wy; logic [63:0] wa, wd, rd; logic e, b;
        run_access(1'b1, 3'b011, 64'h18, 64'h0123456789ABCDEF, dc, wc, wy, wa, wd, e, rd, b);
        checks++; if (wy !== 1) begin errors++; $display("FAIL sd_wr_cycle: got %0d expected 1", wy); end
        checks++; if (wc !== 1) begin errors++; $display("FAIL sd_wr_pulses: got %0d expected 1", wc); end
        checks++; if (wa !== 64'h18) begin errors++; $display("FAIL sd_mem_addr: got %h expected 18", wa); end
        checks++; if (wd !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL sd_mem_wdata: got %h expected 0123456789abcdef", wd); end
        checks++; if (dc !== 2) begin errors++; $display("FAIL sd_done_cycle: got %0d expected 2", dc); end
        run_access(1'b0, 3'b011, 64'h18, 64'd0, dc, wc, wy, wa, wd, e, rd, b);
        checks++; if (rd !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL sd_readback: got %h expected 0123456789abcdef", rd); end
    endtask

    task automatic test_sw();
        int dc, wc, wy; logic [63:0] wa, wd, rd; logic e, b;
        run_access(1'b1, 3'b010, 64'h1C, 64'h11111111CAFEBABE, dc, wc, wy, wa, wd, e, rd, b);
        checks++; if (wd !== 64'hCAFEBABE89ABCDEF) begin errors++; $display("FAIL sw_mem_wdata: got %h expected cafebabe89abcdef", wd); end
        checks++; if (dc !== 4) begin errors++; $display("FAIL sw_done_cycle: got %0d expected 4", dc); end
        run_access(1'b0, 3'b010, 64'h1C, 64'd0, dc, wc, wy, wa, wd, e, rd, b);
        checks++; if (rd !== 64'hFFFFFFFFCAFEBABE) begin errors++; $display("FAIL sw_lw_rdata: got %h expected ffffffffcafebabe", rd); end
        run_access(1'b0, 3'b101, 64'h1E, 64'd0, dc, wc, wy, wa, wd, e, rd, b);
        checks++; if (rd !== 64'h000000000000CAFE) begin errors++; $display("FAIL lhu_rdata: got %h expected cafe", rd); end
    endtask

    task automatic test_errors();
        int dc, wc, wy; logic [63:0] wa, wd, rd; logic e, b;
        logic [2:0]  f3s [4] = '{3'b001, 3'b010, 3'b100, 3'b111};
        logic        wes [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [63:0] ads [4] = '{64'h13, 64'h12, 64'h10, 64'h10};
        for (int i = 0; i < 4; i++) begin
            run_access(wes[i], f3s[i], ads[i], 64'hDEADBEEFDEADBEEF, dc, wc, wy, wa, wd, e, rd, b);
            checks++; if (dc !== 1) begin errors++; $display("FAIL err%0d_done_cycle: got %0d expected 1", i, dc); end
            checks++; if (e !== 1'b1) begin errors++; $display("FAIL err%0d_err: got %b expected 1", i, e); end
            checks++; if (wc !== 0) begin errors++; $display("FAIL err%0d_mem_wr: got %0d pulses expected 0", i, wc); end
            checks++; if (rd !== 64'h000000000000CAFE) begin errors++; $display("FAIL err%0d_rdata_kept: got %h expected cafe", i, rd); end
        end
        run_access(1'b0, 3'b011, 64'h10, 64'd0, dc, wc, wy, wa, wd, e, rd, b);
        checks++; if (rd !== 64'h8877665544AB2211) begin errors++; $display("FAIL err_mem_untouched: got %h expected 8877665544ab2211", rd); end
    endtask

    task automatic test_read_lat3();
        int dc = -1;
        @(negedge Clk);
        b2.req = 1'b1; b2.we = 1'b0; b2.funct3 = 3'b000; b2.addr = 64'h17; b2.wdata = 64'd0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (k == 1) b2.req = 1'b0;
            if (b2.done) begin dc = k; break; end
        end
        checks++; if (dc !== 4) begin errors++; $display("FAIL lat3_done_cycle: got %0d expected 4", dc); end
        checks++; if (b2.rdata !== 64'hFFFFFFFFFFFFFF88) begin errors++; $display("FAIL lat3_rdata: got %h expected ffffffffffffff88", b2.rdata); end
    endtask

    task automatic test_reset_during_wr();
        logic seen = 1'b0;
        int   late_done = 0;
        @(negedge Clk);
        b1.req = 1'b1; b1.we = 1'b1; b1.funct3 = 3'b000; b1.addr = 64'h20; b1.wdata = 64'h55;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (k == 1) b1.req = 1'b0;
            if (b1.mem_wr) begin seen = 1'b1; break; end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstwr_reached_wr: got %b expected 1", seen); end
        Reset = 1'b1;
        @(negedge Clk);
        checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL rstwr_busy: got %b expected 0", b1.busy); end
        checks++; if (b1.mem_wr !== 1'b0) begin errors++; $display("FAIL rstwr_mem_wr: got %b expected 0", b1.mem_wr); end
        checks++; if (b1.done !== 1'b0) begin errors++; $display("FAIL rstwr_done: got %b expected 0", b1.done); end
        Reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (b1.done) late_done++;
        end
        checks++; if (late_done !== 0) begin errors++; $display("FAIL rstwr_no_done: got %0d pulses expected 0", late_done); end
    endtask

    task automatic test_back_to_back();
        int dcyc [4] = '{-1, -1, -1, -1};
        int n = 0;
        @(negedge Clk);
        b1.req = 1'b1; b1.we = 1'b0; b1.funct3 = 3'b000; b1.addr = 64'h17; b1.wdata = 64'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clk);
            if (b1.done && n < 4) begin dcyc[n] = k; n++; end
        end
        b1.req = 1'b0;
        checks++; if (n !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", n); end
        checks++; if (dcyc[0] !== 2) begin errors++; $display("FAIL b2b_first: got %0d expected 2", dcyc[0]); end
        checks++; if (dcyc[1] !== 5) begin errors++; $display("FAIL b2b_second: got %0d expected 5", dcyc[1]); end
        checks++; if (dcyc[2] !== 8) begin errors++; $display("FAIL b2b_third: got %0d expected 8", dcyc[2]); end
        checks++; if (b1.rdata !== 64'hFFFFFFFFFFFFFF88) begin errors++; $display("FAIL b2b_rdata: got %h expected ffffffffffffff88", b1.rdata); end
        repeat (5) @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; preload = 1'b1;
        b1.req = 1'b0; b1.we = 1'b0; b1.funct3 = 3'd0; b1.addr = 64'd0; b1.wdata = 64'd0;
        b2.req = 1'b0; b2.we = 1'b0; b2.funct3 = 3'd0; b2.addr = 64'd0; b2.wdata = 64'd0;
        repeat (3) @(negedge Clk);
        preload = 1'b0;
        test_reset();
        test_loads();
        test_partial_store();
        test_sd();
        test_sw();
        test_errors();
        test_read_lat3();
        test_reset_during_wr();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
